// File: rtl/life_frame_scanner_if.sv
// Handshake bundle between the life engine, the frame scanner and the
// cell-stream sink. The scanner sits on the slave side. The engine and the sink
// together form the master side.
interface life_frame_scanner_if #(
   parameter int N = 10
);
   localparam int RW = $clog2(N);
   localparam int PW = $clog2(N*N+1);

   // generation capture handshake
   logic [N-1:0][N-1:0] grid_in;
   logic                grid_valid;
   logic                grid_ready;

   // row-major cell stream
   logic                cell_valid;
   logic                cell_ready;
   logic                cell_alive;
   logic [RW-1:0]       cell_row;
   logic [RW-1:0]       cell_col;
   logic                cell_last;

   // per-frame statistics
   logic [PW-1:0]       pop_count;
   logic                pop_valid;
   logic                stable;

   modport slave (
      input  grid_in, grid_valid, cell_ready,
      output grid_ready, cell_valid, cell_alive, cell_row, cell_col, cell_last,
             pop_count, pop_valid, stable
   );

   modport master (
      output grid_in, grid_valid, cell_ready,
      input  grid_ready, cell_valid, cell_alive, cell_row, cell_col, cell_last,
             pop_count, pop_valid, stable
   );
endinterface

// File: rtl/life_frame_scanner.sv
// Frame scanner: snapshots one generation of the N x N life grid, streams its
// cells row-major one beat at a time, and reports the population of the frame
// and whether the frame repeats the previous generation.
module life_frame_scanner #(
   parameter int N = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   life_frame_scanner_if.slave  bus
);
   localparam int RW = $clog2(N);
   localparam int PW = $clog2(N*N+1);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_STREAM = 1'b1;

   logic [0:0]          state;
   logic [N-1:0][N-1:0] snapshot;
   logic [N-1:0][N-1:0] prev;
   logic                first;
   logic [RW-1:0]       row;
   logic [RW-1:0]       col;
   logic [PW-1:0]       acc;
   logic [PW-1:0]       pop_count_q;
   logic                pop_valid_q;
   logic                stable_q;

   logic                capture;
   logic                xfer;
   logic                at_last;
   logic                alive;

   // The cell beat is a pure function of state, position and snapshot, so it
   // holds exactly while the sink stalls and drops to zero as soon as reset hits.
   assign alive   = (state == S_STREAM) & snapshot[row][col];
   assign at_last = (row == RW'(N-1)) && (col == RW'(N-1));
   assign capture = bus.grid_valid & (state == S_IDLE);
   assign xfer    = (state == S_STREAM) & bus.cell_ready;

   assign bus.grid_ready = (state == S_IDLE);
   assign bus.cell_valid = (state == S_STREAM);
   assign bus.cell_alive = alive;
   assign bus.cell_row   = row;
   assign bus.cell_col   = col;
   assign bus.cell_last  = (state == S_STREAM) & at_last;
   assign bus.pop_count  = pop_count_q;
   assign bus.pop_valid  = pop_valid_q;
   assign bus.stable     = stable_q;

   // Capture, beat sequencing, population accumulation and frame comparison.
   // NOTE: all state here uses <= so every register samples pre-edge values;
   // the snapshot and prev grids are reset too, so a reset mid-stream leaves
   // no trace of the aborted frame for the next stable comparison.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         snapshot    <= '0;
         prev        <= '0;
         first       <= 1'b1;
         row         <= '0;
         col         <= '0;
         acc         <= '0;
         pop_count_q <= '0;
         pop_valid_q <= 1'b0;
         stable_q    <= 1'b0;
      end else begin
         pop_valid_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (capture) begin
                  snapshot <= bus.grid_in;
                  stable_q <= !first && (bus.grid_in == prev);
                  prev     <= bus.grid_in;
                  first    <= 1'b0;
                  row      <= '0;
                  col      <= '0;
                  acc      <= '0;
                  state    <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (xfer) begin
                  if (at_last) begin
                     pop_count_q <= acc + PW'(alive);
                     pop_valid_q <= 1'b1;
                     row         <= '0;
                     col         <= '0;
                     state       <= S_IDLE;
                  end else begin
                     acc <= acc + PW'(alive);
                     if (col == RW'(N-1)) begin
                        col <= '0;
                        row <= row + RW'(1);
                     end else begin
                        col <= col + RW'(1);
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_life_frame_scanner.sv
// Directed bench for life_frame_scanner: reset state, row-major streaming with
// and without back-pressure, population and stability reporting, capture
// blocking during streaming, back-to-back capture, and reset mid-stream.
module tb_life_frame_scanner;
   localparam int N = 10;
   typedef logic [N-1:0][N-1:0] grid_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   life_frame_scanner_if #(.N(N)) bus ();

   life_frame_scanner #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int popcnt(input grid_t g);
      int n;
      n = 0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            n += int'(g[r][c]);
      return n;
   endfunction

   // All outputs packed: grid_ready, cell_valid, alive, row, col, last, pop_valid, stable, pop_count
   function automatic logic [31:0] outs();
      return {11'd0, bus.grid_ready, bus.cell_valid, bus.cell_alive, bus.cell_row,
              bus.cell_col, bus.cell_last, bus.pop_valid, bus.stable, bus.pop_count};
   endfunction

   // Starts at #1 after an edge with the scanner idle; ends in the pop_valid cycle.
   task automatic run_frame(input grid_t g, input bit alt, input bit exp_stable,
                            input bit hold_valid);
      int          idx;
      int          cyc;
      int          r;
      int          c;
      bit          ph;
      logic [31:0] got;
      logic [31:0] exp;
      check("cap_ready", 32'(bus.grid_ready), 32'd1);
      bus.grid_in    = g;
      bus.grid_valid = 1'b1;
      @(posedge clk); #1;
      if (!hold_valid) bus.grid_valid = 1'b0;
      check("stable", 32'(bus.stable), 32'(exp_stable));
      check("pop_pulse_low", 32'(bus.pop_valid), 32'd0);
      idx = 0;
      cyc = 0;
      ph  = 1'b1;
      while (idx < N*N && cyc < 400) begin
         r = idx / N;
         c = idx % N;
         bus.cell_ready = alt ? ph : 1'b1;
         got = {20'd0, bus.cell_valid, bus.grid_ready, bus.cell_alive,
                bus.cell_row, bus.cell_col, bus.cell_last};
         exp = {20'd0, 1'b1, 1'b0, g[r][c], 4'(r), 4'(c), (idx == N*N-1)};
         check($sformatf("beat%0d", idx), got, exp);
         if (bus.cell_ready) idx++;
         ph = !ph;
         @(posedge clk); #1;
         cyc++;
      end
      bus.cell_ready = 1'b0;
      check("pop_latency", 32'(cyc), alt ? 32'd199 : 32'd100);
      check("pop_valid", 32'(bus.pop_valid), 32'd1);
      check("pop_count", 32'(bus.pop_count), 32'(popcnt(g)));
      check("idle_ready", 32'(bus.grid_ready), 32'd1);
      check("idle_valid", 32'(bus.cell_valid), 32'd0);
   endtask

   grid_t glider, block, ones;

   initial begin
      total = 0;
      bad   = 0;
      glider = '0;
      glider[0][1] = 1'b1; glider[1][2] = 1'b1;
      glider[2][0] = 1'b1; glider[2][1] = 1'b1; glider[2][2] = 1'b1;
      block = '0;
      block[4][4] = 1'b1; block[4][5] = 1'b1; block[5][4] = 1'b1; block[5][5] = 1'b1;
      ones = '1;

      bus.grid_in    = '0;
      bus.grid_valid = 1'b0;
      bus.cell_ready = 1'b0;

      // 1: reset state, then quiet idle after release
      reset = 1'b1;
      #12;
      check("reset_outs", outs(), 32'h0010_0000 >> 0 & 32'h0 | {11'd0, 1'b1, 20'd0});
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("idle_outs", outs(), {11'd0, 1'b1, 20'd0});
      end

      // 2: glider, sink always ready
      run_frame(glider, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("pop_one_cycle", 32'(bus.pop_valid), 32'd0);
      check("pop_hold", 32'(bus.pop_count), 32'd5);

      // 3: glider again with alternating back-pressure (repeats previous frame)
      run_frame(glider, 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;

      // 4: block twice, then all ones
      run_frame(block, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      run_frame(block, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
      run_frame(ones, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("ones_hold", 32'(bus.pop_count), 32'd100);
      check("ones_stable_hold", 32'(bus.stable), 32'd0);

      // 5: grid_valid held through streaming; second capture lands in the pop cycle
      run_frame(glider, 1'b0, 1'b0, 1'b1);
      run_frame(glider, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;

      // 6: reset after beat 40, then resubmit
      bus.grid_in    = glider;
      bus.grid_valid = 1'b1;
      @(posedge clk); #1;
      bus.grid_valid = 1'b0;
      bus.cell_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
      end
      check("abort_pos", {28'd0, bus.cell_row}, 32'd4);
      reset = 1'b1;
      #1;
      check("abort_outs", outs(), {11'd0, 1'b1, 20'd0});
      bus.cell_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("no_pop_after_abort", 32'(bus.pop_valid), 32'd0);
      end
      run_frame(glider, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
